uart_rx_controller: RTL
=======================

# uart_rx_controller

Sequences and consumes the `tt_um_uart_receiver` datapath. It enables the receiver, collects pairs of Hamming(7,4) codewords, and corrects single-bit errors. It assembles each low/high nibble pair into a byte and offers it downstream on a ready/valid handshake. It sits between the receiver and the byte consumer, and also handles graceful shutdown, inter-codeword timeout and overrun reporting.

## Interface
- `TIMEOUT_CYCLES`, default 1024: max enabled cycles allowed between the low and high codeword of one byte.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset. Single clock domain.
- `ena` in 1: global enable. When low, all state and counters freeze.
- `cfg_enable` in 1: software enable for reception.
- `clr_status` in 1: one-cycle pulse that clears the sticky flags.
- `rx_data` in 7: codeword from the receiver (`data_out`).
- `rx_valid` in 1: one-cycle codeword strobe from the receiver (`valid_out`).
- `rx_state` in 2: receiver state. 2'b00 means the receiver is idle.
- `rx_ena` out 1: drives the receiver's `ena`.
- `byte_data` out 8: assembled byte.
- `byte_corrected` out 1: at least one nibble of `byte_data` was corrected.
- `byte_valid` out 1: byte offered.
- `byte_ready` in 1: consumer accepts.
- `err_timeout` out 1: one-cycle pulse when a partial byte is dropped.
- `overrun` out 1: sticky flag; a codeword was lost while holding.
- `corr_count` out 8: saturating count of corrected codewords.

## Operation
- States:
  - OFF: receiver disabled.
  - LO: waiting for the low-nibble codeword.
  - HI: waiting for the high-nibble codeword.
  - HOLD: byte offered downstream.
  - DRAIN: waiting for the receiver to go idle before shutdown.
- `rx_ena = ena && state != OFF` (combinational).
- OFF → LO when `cfg_enable` = 1.
- LO, on `rx_valid`: latch the decoded nibble into `byte_data[3:0]`, record the corrected flag, go to HI, and clear the timeout counter.
- HI, on `rx_valid`: load `byte_data[7:4]`, OR the corrected flag into `byte_corrected`, go to HOLD.
- HI timeout: the counter reaches `TIMEOUT_CYCLES-1` with no `rx_valid`.
  - Pulse `err_timeout` and go back to LO, discarding the low nibble.
  - If `rx_valid` arrives in the same cycle, `rx_valid` wins and there is no timeout.
- HOLD: `byte_valid` = 1. A transfer occurs when `byte_valid && byte_ready`.
  - After transfer, go to LO, or to DRAIN if `cfg_enable` = 0.
  - A `rx_valid` in the transfer cycle is accepted as the new low nibble, going to HI.
  - A `rx_valid` in HOLD without a transfer is dropped and sets `overrun`.
- Disable: `cfg_enable` = 0 in LO or HI goes to DRAIN, discarding any partial byte. In HOLD the byte stays offered until accepted.
- DRAIN: codewords are discarded. Go to OFF when `rx_state == 2'b00`.
- Hamming decode:
  - Codeword positions: `c[0]`=p1, `c[1]`=p2, `c[2]`=d1, `c[3]`=p4, `c[4]`=d2, `c[5]`=d3, `c[6]`=d4.
  - Syndrome bits: s1=`c0^c2^c4^c6`, s2=`c1^c2^c5^c6`, s4=`c3^c4^c5^c6`.
  - A nonzero syndrome S flips `c[S-1]` and marks the codeword corrected.
  - Nibble = {`c6`,`c5`,`c4`,`c2`}.
- `corr_count` increments once per corrected codeword that is accepted in LO or HI, and saturates at 255. `clr_status` clears `overrun` and `corr_count`.
- `clr_status` concurrent with an overrun event: the set wins.

## Timing
- Reset values: state OFF, `rx_ena` 0, `byte_data` 0x00, `byte_corrected` 0, `byte_valid` 0, `err_timeout` 0, `overrun` 0, `corr_count` 0.
- Decode is combinational on `rx_data` and registered on `rx_valid`. `byte_valid` rises the cycle after the high-nibble `rx_valid`.
- `byte_data` and `byte_corrected` hold stable while `byte_valid && !byte_ready`.
- `byte_valid` falls the cycle after a transfer.
- The timeout counter only advances while `ena` = 1.
- Reset mid-byte discards everything and returns to OFF immediately.
- `ena` = 0 in HOLD: `byte_valid` stays asserted, but no transfer is counted.

## Structure
- Package `uart_ctrl_pkg` holds the state enum and the Hamming position constants, which the transmitter-side encoder shares.
- Sub-module `hamming74_decode` is combinational: `code[6:0]` → `nibble[3:0]`, `corrected`.

## Test plan
- Clean byte: `cfg_enable`=1, `rx_valid` with 0x2D then 0x52 → `byte_data`=0xA5, `byte_corrected`=0, `byte_valid` one cycle after the 2nd strobe.
- Single-bit error: 0x3D (`c4` flipped) then 0x52 → `byte_data`=0xA5, `byte_corrected`=1, `corr_count`=1.
- Timeout: `TIMEOUT_CYCLES`=16, send 0x2D, then nothing → `err_timeout` pulse on cycle 16, state LO. Then 0x2D, 0x52 → 0xA5.
- Backpressure: hold `byte_ready`=0, send a third codeword → `overrun`=1, first byte unchanged. `clr_status` → `overrun`=0.
- Back-to-back: `byte_ready` high in the same cycle as the next `rx_valid` (0x2D) → transfer plus new low nibble accepted, no overrun.
- Shutdown: `cfg_enable`=0 while `rx_state`=2'b10 → `rx_ena` stays 1 until `rx_state`=00, then 0 next cycle. A codeword received in DRAIN produces no byte.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART receive controller.
//   ctrl_state_t : controller sequencing states
//   HAM_*        : Hamming(7,4) bit positions inside a codeword; the
//                  transmitter-side encoder uses the same table
//   RX_IDLE      : receiver state code meaning "idle"
package uart_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_OFF   = 3'd0,
      ST_LO    = 3'd1,
      ST_HI    = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DRAIN = 3'd4
   } ctrl_state_t;

   localparam int HAM_P1 = 0;
   localparam int HAM_P2 = 1;
   localparam int HAM_D1 = 2;
   localparam int HAM_P4 = 3;
   localparam int HAM_D2 = 4;
   localparam int HAM_D3 = 5;
   localparam int HAM_D4 = 6;

   localparam logic [1:0] RX_IDLE = 2'b00;

endpackage

// File: rtl/hamming74_decode.sv
// Combinational Hamming(7,4) single-error-correcting decoder.
//   code[6:0]   : received codeword
//   nibble[3:0] : corrected data {d4,d3,d2,d1}
//   corrected   : syndrome was nonzero and one bit was flipped
module hamming74_decode
   import uart_ctrl_pkg::*;
(
   input  logic [6:0] code,
   output logic [3:0] nibble,
   output logic       corrected
);

   logic [2:0] syndrome;
   logic [6:0] fixed;

   always_comb begin
      syndrome[0] = code[HAM_P1] ^ code[HAM_D1] ^ code[HAM_D2] ^ code[HAM_D4];
      syndrome[1] = code[HAM_P2] ^ code[HAM_D1] ^ code[HAM_D3] ^ code[HAM_D4];
      syndrome[2] = code[HAM_P4] ^ code[HAM_D2] ^ code[HAM_D3] ^ code[HAM_D4];
      corrected   = (syndrome != 3'd0);
      // Syndrome value S names the 1-based position of the bad bit.
      fixed       = corrected ? (code ^ (7'b1 << (syndrome - 3'd1))) : code;
      nibble      = {fixed[HAM_D4], fixed[HAM_D3], fixed[HAM_D2], fixed[HAM_D1]};
   end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive controller: enables the receiver, pairs low/high Hamming
// codewords into bytes, and offers them on a ready/valid handshake.
//   clk, rst_n      : clock, async active-low reset
//   ena             : global enable, freezes everything when low
//   cfg_enable      : software enable for reception
//   clr_status      : clears overrun and corr_count
//   rx_data/valid   : codeword and strobe from the receiver
//   rx_state        : receiver state (2'b00 = idle)
//   rx_ena          : receiver enable
//   byte_data/corrected/valid, byte_ready : downstream byte handshake
//   err_timeout     : pulse when a partial byte is dropped on timeout
//   overrun         : sticky, codeword lost while a byte was held
//   corr_count      : saturating count of corrected codewords
//
// state | meaning
// OFF   | receiver disabled
// LO    | waiting for low-nibble codeword
// HI    | waiting for high-nibble codeword, timeout running
// HOLD  | byte offered downstream
// DRAIN | shutting down, waiting for receiver idle
module uart_rx_controller
   import uart_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       cfg_enable,
   input  logic       clr_status,
   input  logic [6:0] rx_data,
   input  logic       rx_valid,
   input  logic [1:0] rx_state,
   output logic       rx_ena,
   output logic [7:0] byte_data,
   output logic       byte_corrected,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       err_timeout,
   output logic       overrun,
   output logic [7:0] corr_count
);

   localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

   ctrl_state_t      state, state_nxt;
   logic [3:0]       dec_nibble;
   logic             dec_corr;
   logic [CNT_W-1:0] tmo_cnt;
   logic             accept_lo, accept_hi, overrun_set, tmo_hit;

   hamming74_decode u_dec (
      .code      (rx_data),
      .nibble    (dec_nibble),
      .corrected (dec_corr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_OFF;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      accept_lo   = 1'b0;
      accept_hi   = 1'b0;
      overrun_set = 1'b0;
      tmo_hit     = 1'b0;
      if (ena) begin
         case (state)
            ST_OFF: if (cfg_enable) state_nxt = ST_LO;
            ST_LO: begin
               if (!cfg_enable) state_nxt = ST_DRAIN;
               else if (rx_valid) begin
                  accept_lo = 1'b1;
                  state_nxt = ST_HI;
               end
            end
            ST_HI: begin
               if (!cfg_enable) state_nxt = ST_DRAIN;
               else if (rx_valid) begin
                  accept_hi = 1'b1;
                  state_nxt = ST_HOLD;
               end else if (tmo_cnt == '0) begin
                  tmo_hit   = 1'b1;
                  state_nxt = ST_LO;
               end
            end
            ST_HOLD: begin
               if (byte_ready) begin
                  // A codeword arriving with the transfer starts the next byte.
                  if (!cfg_enable) state_nxt = ST_DRAIN;
                  else if (rx_valid) begin
                     accept_lo = 1'b1;
                     state_nxt = ST_HI;
                  end else state_nxt = ST_LO;
               end else if (rx_valid) overrun_set = 1'b1;
            end
            ST_DRAIN: if (rx_state == RX_IDLE) state_nxt = ST_OFF;
            default: state_nxt = ST_OFF;
         endcase
      end
   end

   assign rx_ena      = ena && (state != ST_OFF);
   assign byte_valid  = (state == ST_HOLD);
   assign err_timeout = tmo_hit;

   // Down-counter: loaded on the low nibble, timeout at terminal count zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tmo_cnt <= CNT_LOAD;
      else if (accept_lo) tmo_cnt <= CNT_LOAD;
      else if (ena && state == ST_HI && tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_data      <= 8'h00;
         byte_corrected <= 1'b0;
      end else if (accept_lo) begin
         byte_data[3:0] <= dec_nibble;
         byte_corrected <= dec_corr;
      end else if (accept_hi) begin
         byte_data[7:4] <= dec_nibble;
         byte_corrected <= byte_corrected | dec_corr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun    <= 1'b0;
         corr_count <= 8'h00;
      end else begin
         if (overrun_set)             overrun <= 1'b1;
         else if (ena && clr_status)  overrun <= 1'b0;
         if (ena && clr_status) corr_count <= 8'h00;
         else if ((accept_lo || accept_hi) && dec_corr && corr_count != 8'hFF)
            corr_count <= corr_count + 8'h01;
      end
   end

endmodule
